// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: time-base and mode encodings plus a width helper.
// No ports; imported by timer_chan and timer_bank.
package timer_bank_pkg;

  localparam logic [1:0] BASE_MILI     = 2'b00;
  localparam logic [1:0] BASE_DECI     = 2'b01;
  localparam logic [1:0] BASE_SEC      = 2'b10;
  localparam logic [1:0] BASE_MIN      = 2'b11;

  localparam logic       MODE_ONESHOT  = 1'b0;
  localparam logic       MODE_PERIODIC = 1'b1;

  // Keeps derived vector widths legal when $clog2 collapses to zero.
  function automatic int unsigned at_least_one(int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One programmable timer channel: stored config, prescaler, base-tick count and the
// registered tick / sticky pend / running flags.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   cfg_we, stop_we, ack_we    per-channel strobes, already decoded by the top
//   cfg_base, cfg_umbral,      configuration captured on cfg_we
//   cfg_mode
//   tick                       one-cycle expiry pulse
//   pend                       sticky expiry flag, cleared by ack_we
//   running                    channel armed and counting
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int unsigned TH_W = 6,
  parameter int unsigned DIV0 = 20,
  parameter int unsigned DIV1 = 2000,
  parameter int unsigned DIV2 = 20000,
  parameter int unsigned DIV3 = 1200000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic            stop_we,
  input  logic            ack_we,
  input  logic [1:0]      cfg_base,
  input  logic [TH_W-1:0] cfg_umbral,
  input  logic            cfg_mode,
  output logic            tick,
  output logic            pend,
  output logic            running
);

  localparam int unsigned PW = at_least_one($clog2(DIV3));

  logic [1:0]      base_q;
  logic [TH_W-1:0] umbral_q;
  logic            mode_q;
  logic [PW-1:0]   presc_q, presc_d, div_last;
  logic [TH_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            tick_q, tick_d, pend_q, pend_d, run_q, run_d;
  logic            base_tick, expire;

  always_comb begin
    div_last = '0;
    unique case (base_q)
      BASE_MILI: div_last = PW'(DIV0 - 1);
      BASE_DECI: div_last = PW'(DIV1 - 1);
      BASE_SEC:  div_last = PW'(DIV2 - 1);
      BASE_MIN:  div_last = PW'(DIV3 - 1);
    endcase
  end

  assign cnt_inc   = cnt_q + TH_W'(1);
  assign base_tick = run_q && (presc_q == div_last);
  assign expire    = base_tick && (cnt_inc == umbral_q);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    // Ack is applied first so that a same-cycle expiry below overrides it.
    if (ack_we) pend_d = 1'b0;
    if (cfg_we) begin
      presc_d = '0;
      cnt_d   = '0;
      run_d   = |cfg_umbral;
    end else if (stop_we) begin
      presc_d = '0;
      cnt_d   = '0;
      run_d   = 1'b0;
    end else if (run_q) begin
      if (base_tick) begin
        presc_d = '0;
        if (expire) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          pend_d = 1'b1;
          run_d  = (mode_q == MODE_PERIODIC);
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      umbral_q <= '0;
      mode_q   <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      if (cfg_we) begin
        base_q   <= cfg_base;
        umbral_q <= cfg_umbral;
        mode_q   <= cfg_mode;
      end
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
    end
  end

  assign tick    = tick_q;
  assign pend    = pend_q;
  assign running = run_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent programmable timers sharing one configuration port.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   cfg_we                     write config to channel cfg_ch and (re)start it
//   cfg_ch                     channel select for cfg_we / stop_we / ack_we
//   cfg_base, cfg_umbral,      time base, threshold and one-shot/periodic mode
//   cfg_mode
//   stop_we                    stop channel cfg_ch
//   ack_we                     clear pend[cfg_ch]
//   tick, pend, running        per-channel expiry pulse, sticky flag, armed status
//   irq                        OR of all pend flags
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned TH_W = 6,
  parameter int unsigned DIV0 = 20,
  parameter int unsigned DIV1 = 2000,
  parameter int unsigned DIV2 = 20000,
  parameter int unsigned DIV3 = 1200000,
  parameter int unsigned CH_W = at_least_one($clog2(NCH))
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_base,
  input  logic [TH_W-1:0] cfg_umbral,
  input  logic            cfg_mode,
  input  logic            stop_we,
  input  logic            ack_we,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  pend,
  output logic [NCH-1:0]  running,
  output logic            irq
);

  logic [NCH-1:0] sel;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    // Full-width compare: a cfg_ch at or beyond NCH selects no channel.
    assign sel[i] = (cfg_ch == CH_W'(i));

    timer_chan #(
      .TH_W (TH_W),
      .DIV0 (DIV0),
      .DIV1 (DIV1),
      .DIV2 (DIV2),
      .DIV3 (DIV3)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we && sel[i]),
      .stop_we    (stop_we && sel[i]),
      .ack_we     (ack_we && sel[i]),
      .cfg_base   (cfg_base),
      .cfg_umbral (cfg_umbral),
      .cfg_mode   (cfg_mode),
      .tick       (tick[i]),
      .pend       (pend[i]),
      .running    (running[i])
    );
  end

  assign irq = |pend;

endmodule
